// File: rtl/csr_led_pwm.sv
// CSR-mapped LED controller: per-channel off/on/PWM/blink driven from one shared
// prescaled 8-bit period counter. CTRL, DUTY and PRESC sit at Addr..Addr+2.
package csr_led_pwm_pkg;
    typedef logic [11:0] csr_addr_t;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {CSR_RW = 2'd0, CSR_RS = 2'd1, CSR_RC = 2'd2} csr_t;
    typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_PWM, MODE_BLINK} mode_t;
endpackage

// One LED channel: period-boundary duty shadow plus the registered drive.
module csr_led_pwm_ch
    import csr_led_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [7:0] pcyc,
    input  logic       reload,
    input  logic [7:0] duty_nxt,
    output logic       led
);
    logic [7:0] shadow;
    mode_t      md;

    assign md = mode_t'(mode);

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            led    <= 1'b0;
        end else begin
            // Shadow only moves at the period boundary so a PWM period never glitches.
            if (reload)
                shadow <= duty_nxt;
            case (md)
                MODE_OFF:   led <= 1'b0;
                MODE_ON:    led <= 1'b1;
                MODE_PWM:   led <= (pcyc < shadow);
                MODE_BLINK: led <= pcyc[7];
                default:    led <= 1'b0;
            endcase
        end
    end
endmodule

module csr_led_pwm
    import csr_led_pwm_pkg::*;
#(
    parameter csr_addr_t Addr       = '0,
    parameter int        NumLeds    = 4,
    parameter int        PrescWidth = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  csr_addr_t          addr,
    input  reg_idx_t           rs1,
    input  reg_idx_t           rd,
    input  csr_t               op,
    input  word_t              in,
    output word_t              old,
    output logic [NumLeds-1:0] led
);
    localparam int        CW        = 2 * NumLeds;
    localparam int        DW        = 8 * NumLeds;
    localparam csr_addr_t AddrDuty  = csr_addr_t'(Addr + 1);
    localparam csr_addr_t AddrPresc = csr_addr_t'(Addr + 2);

    logic [CW-1:0]         ctrl;
    logic [DW-1:0]         duty;
    logic [DW-1:0]         duty_nxt;
    logic [PrescWidth-1:0] presc;
    logic [PrescWidth-1:0] pcnt;
    logic [7:0]            pcyc;

    logic  hit_ctrl, hit_duty, hit_presc;
    logic  wr_ok, ctrl_we, duty_we, presc_we;
    logic  tick, boundary;
    word_t wr_val;

    assign hit_ctrl  = (addr == Addr);
    assign hit_duty  = (addr == AddrDuty);
    assign hit_presc = (addr == AddrPresc);

    always_comb begin
        old = '0;
        if (hit_ctrl)
            old = word_t'(ctrl);
        else if (hit_duty)
            old = word_t'(duty);
        else if (hit_presc)
            old = word_t'(presc);
    end

    always_comb begin
        case (op)
            CSR_RW:  wr_val = in;
            CSR_RS:  wr_val = old | in;
            CSR_RC:  wr_val = old & ~in;
            default: wr_val = old;
        endcase
    end

    // Set/clear with rs1 == x0 is a pure read.
    assign wr_ok    = en && ((op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && (rs1 != '0)));
    assign ctrl_we  = wr_ok && hit_ctrl;
    assign duty_we  = wr_ok && hit_duty;
    assign presc_we = wr_ok && hit_presc;

    // A PRESC write restarts the prescaler and swallows any tick on that edge.
    assign tick     = !presc_we && (pcnt == presc);
    assign boundary = tick && (pcyc == 8'hFF);
    assign duty_nxt = duty_we ? wr_val[DW-1:0] : duty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl  <= '0;
            duty  <= '0;
            presc <= '0;
            pcnt  <= '0;
            pcyc  <= '0;
        end else begin
            if (ctrl_we)
                ctrl <= wr_val[CW-1:0];
            if (duty_we)
                duty <= wr_val[DW-1:0];
            if (presc_we)
                presc <= wr_val[PrescWidth-1:0];

            if (presc_we || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PrescWidth'(1);

            if (tick)
                pcyc <= pcyc + 8'd1;
        end
    end

    csr_led_pwm_ch u_ch [NumLeds-1:0] (
        .clk      (clk),
        .reset    (reset),
        .mode     (ctrl),
        .pcyc     (pcyc),
        .reload   (boundary),
        .duty_nxt (duty_nxt),
        .led      (led)
    );

    logic unused_ok;
    assign unused_ok = ^{rd, wr_val};
endmodule

// File: tb/tb_csr_led_pwm.sv
// Bench for csr_led_pwm: CSR vector table, PWM/blink/boundary/reset sequences and a
// randomized run, all checked against a cycle-level behavioural model.
module tb_csr_led_pwm;
    import csr_led_pwm_pkg::*;

    localparam csr_addr_t A  = 12'h7C0;
    localparam int        N  = 4;
    localparam int        PW = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    csr_addr_t    addr;
    reg_idx_t     rs1, rd;
    csr_t         op;
    word_t        in, old;
    logic [N-1:0] led;

    always #5 clk = ~clk;

    csr_led_pwm #(.Addr(A), .NumLeds(N), .PrescWidth(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .addr  (addr),
        .rs1   (rs1),
        .rd    (rd),
        .op    (op),
        .in    (in),
        .old   (old),
        .led   (led)
    );

    int errs   = 0;
    int checks = 0;
    bit chk_on = 0;

    // Model: register images, cycles since prescaler restart, tick count mod 256.
    int           m_ctrl, m_duty, m_presc, m_ticks;
    longint       m_n;
    int           m_shadow[N];
    logic [N-1:0] m_led;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out waiting for led activity", name);
    endtask

    function automatic word_t model_old();
        if (addr == A)          return word_t'(m_ctrl);
        if (addr == A + 12'd1)  return word_t'(m_duty);
        if (addr == A + 12'd2)  return word_t'(m_presc);
        return '0;
    endfunction

    task automatic model_clear();
        m_ctrl = 0; m_duty = 0; m_presc = 0; m_n = 0; m_ticks = 0; m_led = '0;
        for (int i = 0; i < N; i++) m_shadow[i] = 0;
    endtask

    // One clock: check old before the edge, advance model, check led after it.
    task automatic step();
        word_t        mo, nv;
        bit           we, tick, bnd;
        int           pc, md;
        logic [N-1:0] nl;
        #1;
        mo = model_old();
        if (chk_on) check("old", old, mo);
        pc = m_ticks;
        for (int i = 0; i < N; i++) begin
            md = (m_ctrl >> (2 * i)) & 3;
            case (md)
                0:       nl[i] = 1'b0;
                1:       nl[i] = 1'b1;
                2:       nl[i] = (pc < m_shadow[i]);
                default: nl[i] = (pc >= 128);
            endcase
        end
        we   = en && (addr == A || addr == A + 12'd1 || addr == A + 12'd2) && (op == CSR_RW || rs1 != 0);
        nv   = (op == CSR_RW) ? in : (op == CSR_RS) ? (mo | in) : (mo & ~in);
        tick = !(we && addr == A + 12'd2) && ((m_n % (m_presc + 1)) == m_presc);
        bnd  = tick && (pc == 255);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (we && addr == A)         m_ctrl  = int'(nv & 32'hFF);
            if (we && addr == A + 12'd1) m_duty  = int'(nv);
            if (we && addr == A + 12'd2) m_presc = int'(nv & 32'hFFFF);
            if (bnd)
                for (int i = 0; i < N; i++) m_shadow[i] = (m_duty >> (8 * i)) & 255;
            m_n = (we && addr == A + 12'd2) ? 0 : m_n + 1;
            if (tick) m_ticks = (m_ticks + 1) % 256;
            m_led = nl;
        end
        #1;
        if (chk_on) check("led", led, m_led);
    endtask

    task automatic wr(int off, word_t v);
        en = 1'b1; op = CSR_RW; rs1 = 5'd1; addr = csr_addr_t'(A + off); in = v;
        step();
        en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_rise(int ch, int lim, output int k, output bit ok);
        k = 0; ok = 0;
        while (k < lim) begin
            step();
            k++;
            if (led[ch]) begin ok = 1; break; end
        end
    endtask

    // Counts high samples over n steps; optionally writes DUTY when model pcyc == wr_at.
    task automatic win(int ch, int n, int wr_at, word_t wval, output int hi);
        hi = 0;
        repeat (n) begin
            if (m_ticks == wr_at) begin
                en = 1'b1; op = CSR_RW; rs1 = 5'd1; addr = A + 12'd1; in = wval;
            end else begin
                en = 1'b0;
            end
            step();
            en = 1'b0;
            hi += int'(led[ch]);
        end
    endtask

    typedef struct {
        logic     en;
        int       off;
        csr_t     op;
        reg_idx_t rs1;
        word_t    in;
        word_t    exp_old;
        logic     chk_led;
        logic [3:0] exp_led;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, hi, n, nt;
        bit  ok;
        int  tt[3];
        logic prev;

        tbl[0] = '{1'b1, 0, CSR_RW, 5'd1, 32'h1,        32'h1,        1'b1, 4'b0001};
        tbl[1] = '{1'b1, 0, CSR_RS, 5'd2, 32'h4,        32'h5,        1'b1, 4'b0011};
        tbl[2] = '{1'b1, 0, CSR_RC, 5'd3, 32'h1,        32'h4,        1'b1, 4'b0010};
        tbl[3] = '{1'b1, 0, CSR_RS, 5'd0, 32'h3,        32'h4,        1'b1, 4'b0010};
        tbl[4] = '{1'b0, 0, CSR_RW, 5'd1, 32'h0,        32'h4,        1'b1, 4'b0010};
        tbl[5] = '{1'b1, 5, CSR_RW, 5'd1, 32'hFFFF,     32'h0,        1'b1, 4'b0010};
        tbl[6] = '{1'b1, 1, CSR_RW, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 4'b0010};
        tbl[7] = '{1'b1, 2, CSR_RW, 5'd1, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 4'b0010};
        tbl[8] = '{1'b1, 0, CSR_RW, 5'd1, 32'hFFFFFFFF, 32'h000000FF, 1'b0, 4'b0000};
        tbl[9] = '{1'b1, 0, CSR_RC, 5'd1, 32'hFF,       32'h0,        1'b1, 4'b0000};

        reset = 1'b1; en = 1'b0; addr = A; op = CSR_RW; rs1 = '0; rd = '0; in = '0;
        model_clear();
        step(); step();
        chk_on = 1;
        reset  = 1'b0;

        // Reset state on all three registers plus two unmapped addresses.
        for (int off = 0; off < 4; off++) begin
            addr = csr_addr_t'(A + off);
            step();
            check($sformatf("rst_old[%0d]", off), old, 32'h0);
            check($sformatf("rst_led[%0d]", off), led, 32'h0);
        end
        addr = 12'h000;
        step();
        check("rst_old_nomatch", old, 32'h0);

        foreach (tbl[i]) begin
            en = tbl[i].en; addr = csr_addr_t'(A + tbl[i].off); op = tbl[i].op;
            rs1 = tbl[i].rs1; in = tbl[i].in; rd = 5'd7;
            step();
            en = 1'b0;
            #1;
            check($sformatf("tbl_old[%0d]", i), old, tbl[i].exp_old);
            step();
            if (tbl[i].chk_led) check($sformatf("tbl_led[%0d]", i), led, 32'(tbl[i].exp_led));
        end

        // PWM, PRESC=0, duty 64: first high at the first boundary, then 64/256 per period.
        do_reset();
        wr(1, 32'd64);
        wr(0, 32'h2);
        wait_rise(0, 600, k, ok);
        if (!ok) timeout("pwm_start");
        else begin
            check("pwm_start_delay", k, 255);
            win(0, 255, -1, 0, hi);
            check("pwm_hi[0]", hi + 1, 64);
            for (int w = 1; w < 4; w++) begin
                win(0, 256, -1, 0, hi);
                check($sformatf("pwm_hi[%0d]", w), hi, 64);
            end
        end

        // Blink, PRESC=3: toggles every 128 ticks * 4 cycles.
        do_reset();
        wr(2, 32'd3);
        wr(0, 32'hC);
        prev = led[1]; n = 0; nt = 0;
        while (n < 2000 && nt < 3) begin
            step();
            n++;
            if (led[1] !== prev) begin tt[nt] = n; nt++; prev = led[1]; end
        end
        if (nt < 3) timeout("blink");
        else begin
            check("blink_half0", tt[1] - tt[0], 512);
            check("blink_half1", tt[2] - tt[1], 512);
        end

        // Mid-period duty change, then a DUTY write on the boundary edge.
        do_reset();
        wr(1, 32'd64);
        wr(0, 32'h2);
        wait_rise(0, 600, k, ok);
        if (!ok) timeout("mid_start");
        else begin
            win(0, 255, 100, 32'd200, hi);
            check("mid_cur", hi + 1, 64);
            win(0, 256, -1, 0, hi);
            check("mid_next", hi, 200);
            n = 0;
            while (m_ticks != 255 && n < 300) begin step(); n++; end
            wr(1, 32'd32);
            wait_rise(0, 10, k, ok);
            if (!ok) timeout("bnd_start");
            else begin
                check("bnd_delay", k, 1);
                win(0, 255, -1, 0, hi);
                check("bnd_hi", hi + 1, 32);
            end
        end

        // Reset during a PWM high phase with a colliding CTRL write.
        do_reset();
        wr(1, 32'd128);
        wr(0, 32'h2);
        wait_rise(0, 600, k, ok);
        if (!ok) timeout("rstmid_start");
        else begin
            reset = 1'b1; en = 1'b1; addr = A; op = CSR_RW; rs1 = 5'd1; in = 32'h3;
            step();
            reset = 1'b0; en = 1'b0;
            check("rstmid_led", led, 32'h0);
            check("rstmid_ctrl", old, 32'h0);
            wr(0, 32'h3);
            wait_rise(0, 300, k, ok);
            if (!ok) timeout("rstmid_blink");
            else check("rstmid_blink_delay", k, 128);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int off;
            reset = ($urandom_range(0, 99) == 0);
            en    = $urandom_range(0, 1);
            off   = $urandom_range(0, 4);
            addr  = csr_addr_t'(A + off);
            op    = csr_t'($urandom_range(0, 2));
            rs1   = reg_idx_t'($urandom_range(0, 3));
            rd    = reg_idx_t'($urandom_range(0, 31));
            in    = (off == 2) ? word_t'($urandom_range(0, 5)) : word_t'($urandom);
            step();
        end
        reset = 1'b0; en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
